// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
//
// Owns the fetch program counter, applies branch-unit redirects and keeps a
// circular return-address stack so call/return pairs nest.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   PCSrc      in   take redirect this cycle
//   eN         in   branch/call target
//   is_call    in   redirect is a call (push PC+1)
//   is_ret     in   instruction is a return (pop stack)
//   stall      in   hold PC and stack this cycle
//   halt       in   enter HALT
//   resume     in   leave HALT
//   PC         out  current fetch address
//   ra         out  top of return-address stack (0 when empty)
//   ras_empty  out  stack holds no entries
//   ras_full   out  stack holds RAS_DEPTH entries
//   ras_ovf    out  sticky: push while full
//   ras_unf    out  sticky: pop while empty
//   halted     out  sequencer is in HALT

module pc_sequencer #(
   parameter int              PC_W      = 8,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrc,
   input  logic [PC_W-1:0] eN,
   input  logic            is_call,
   input  logic            is_ret,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   output logic [PC_W-1:0] PC,
   output logic [PC_W-1:0] ra,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf,
   output logic            halted
);

   localparam int            PW       = $clog2(RAS_DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(RAS_DEPTH);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ras_q [RAS_DEPTH];
   logic [PC_W-1:0] ras_d [RAS_DEPTH];
   // ptr is the next write slot; it wraps freely so an overflowing push
   // lands on the oldest entry. cnt tracks occupancy separately.
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] top;
   logic            empty;
   logic            full;

   assign pc_inc = pc_q + PC_W'(1);
   assign top    = ras_q[ptr_q - PW'(1)];
   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == FULL_CNT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ras_d   = ras_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      case (state_q)
         S_HALT: begin
            if (resume) begin
               state_d = S_RUN;
            end
         end
         default: begin
            if (!stall) begin
               if (is_ret) begin
                  if (!empty) begin
                     pc_d  = top;
                     ptr_d = ptr_q - PW'(1);
                     cnt_d = cnt_q - (PW+1)'(1);
                  end else begin
                     pc_d  = pc_inc;
                     unf_d = 1'b1;
                  end
               end else if (PCSrc && is_call) begin
                  ras_d[ptr_q] = pc_inc;
                  ptr_d        = ptr_q + PW'(1);
                  if (full) begin
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + (PW+1)'(1);
                  end
                  pc_d = eN;
               end else if (PCSrc) begin
                  pc_d = eN;
               end else begin
                  pc_d = pc_inc;
               end
               // The redirect of the halting cycle still takes effect.
               if (halt) begin
                  state_d = S_HALT;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= ras_d[i];
         end
      end
   end

   assign PC        = pc_q;
   assign ra        = empty ? '0 : top;
   assign ras_empty = empty;
   assign ras_full  = full;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;
   assign halted    = (state_q == S_HALT);

endmodule
